// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Shared definitions for the PLL reset sequencer: the sequencer state
//   encoding, the default timing constants and a small elaboration helper.
//   Default timings assume the 50 MHz free-running reference clock.

package pll_seq_pkg;

  // Sequencer states, in the order a normal power-up walks through them.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,  // holding the PLL in reset
    WAIT_LOCK = 3'd1,  // PLL released, waiting for synchronised lock
    STABLE    = 3'd2,  // lock seen, qualifying it over a run of cycles
    REL_SYS   = 3'd3,  // CORDIC core released, peripherals still held
    RUN       = 3'd4,  // everything released
    FAIL      = 3'd5   // retries exhausted, parked until reset_n
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 50000;  // 1 ms at 50 MHz
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_STAGE_GAP      = 16;
  localparam int DEF_MAX_RETRY      = 3;
  localparam int DEF_CNT_W          = 8;

  // Largest of four counts; sizes the single shared state timer.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// sync_bit
//   Multi-flop synchroniser for a single asynchronous status bit entering the
//   clk domain. No reset on the data path so the chain is a plain flop string.
// Ports
//   clk  in  1  destination clock
//   d    in  1  asynchronous input
//   q    out 1  synchronised output, STAGES cycles of latency

module sync_bit #(
  parameter int STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          sync_q[0] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Drives the PLL reset input and produces staged active-low resets for the
//   CORDIC core (sys_rst_n) and its peripherals (periph_rst_n). Lock is
//   synchronised, then qualified over STABLE_CYCLES consecutive cycles before
//   any reset is released. Loss of lock after release re-asserts both resets
//   and restarts the PLL. Lock attempts time out and are retried; after
//   MAX_RETRY retries the block parks in FAIL. Loss-of-lock events are counted
//   (saturating) for debug. Must be clocked from the free-running reference
//   clock, never from a PLL output.
// Ports
//   clk           in   1      reference clock
//   reset_n       in   1      synchronous active-low reset
//   pll_locked    in   1      PLL lock status, asynchronous to clk
//   pll_rst       out  1      active-high PLL reset
//   sys_rst_n     out  1      active-low reset, CORDIC core (released first)
//   periph_rst_n  out  1      active-low reset, peripherals (released second)
//   ready         out  1      high only in RUN
//   fail          out  1      sticky high in FAIL
//   lol_clear     in   1      synchronous clear of lol_count (wins over increment)
//   lol_count     out  CNT_W  saturating loss-of-lock count

module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,  // must be >= 2
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             periph_rst_n,
  output logic             ready,
  output logic             fail,
  input  logic             lol_clear,
  output logic [CNT_W-1:0] lol_count
);

  // Timer only ever counts up to (largest count - 1).
  localparam int TMAX = max_of4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP);
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0]    PLL_RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    GAP_LAST     = TW'(STAGE_GAP - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;

  logic lk;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .d   (pll_locked),
    .q   (lk)
  );

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0] lol_count_q, lol_count_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             periph_rst_n_q, periph_rst_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lol_inc;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q + TW'(1);
    retry_d        = retry_q;
    pll_rst_d      = pll_rst_q;
    sys_rst_n_d    = sys_rst_n_q;
    periph_rst_n_d = periph_rst_n_q;
    ready_d        = ready_q;
    fail_d         = fail_q;
    lol_inc        = 1'b0;

    case (state_q)
      PLL_RST: begin
        pll_rst_d      = 1'b1;
        sys_rst_n_d    = 1'b0;
        periph_rst_n_d = 1'b0;
        ready_d        = 1'b0;
        if (timer_q == PLL_RST_LAST) begin
          state_d   = WAIT_LOCK;
          timer_d   = '0;
          pll_rst_d = 1'b0;
        end
      end

      WAIT_LOCK: begin
        pll_rst_d = 1'b0;
        if (lk) begin
          // The cycle that saw lk here is the first of the qualifying run,
          // so STABLE starts its count at 1.
          state_d = STABLE;
          timer_d = TW'(1);
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          if (retry_q == RETRY_LIMIT) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else begin
            retry_d   = retry_q + RW'(1);
            state_d   = PLL_RST;
            pll_rst_d = 1'b1;
          end
        end
      end

      STABLE: begin
        if (!lk) begin
          // Any dropout restarts both the qualification and the timeout budget.
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d     = REL_SYS;
          timer_d     = '0;
          sys_rst_n_d = 1'b1;
        end
      end

      REL_SYS: begin
        if (!lk) begin
          lol_inc = 1'b1;
        end else if (timer_q == GAP_LAST) begin
          state_d        = RUN;
          timer_d        = '0;
          periph_rst_n_d = 1'b1;
          ready_d        = 1'b1;
          retry_d        = '0;
        end
      end

      RUN: begin
        timer_d = timer_q;
        if (!lk) begin
          lol_inc = 1'b1;
        end
      end

      FAIL: begin
        timer_d        = timer_q;
        pll_rst_d      = 1'b0;
        sys_rst_n_d    = 1'b0;
        periph_rst_n_d = 1'b0;
        ready_d        = 1'b0;
        fail_d         = 1'b1;
      end

      default: begin
        state_d = PLL_RST;
        timer_d = '0;
      end
    endcase

    // Loss of lock after release: both resets drop together on this edge.
    if (lol_inc) begin
      state_d        = PLL_RST;
      timer_d        = '0;
      pll_rst_d      = 1'b1;
      sys_rst_n_d    = 1'b0;
      periph_rst_n_d = 1'b0;
      ready_d        = 1'b0;
    end
  end

  // Clear has priority so a clear coinciding with an event leaves 0.
  always_comb begin
    lol_count_d = lol_count_q;
    if (lol_clear) begin
      lol_count_d = '0;
    end else if (lol_inc && (lol_count_q != CNT_SAT)) begin
      lol_count_d = lol_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= PLL_RST;
      timer_q        <= '0;
      retry_q        <= '0;
      lol_count_q    <= '0;
      pll_rst_q      <= 1'b1;
      sys_rst_n_q    <= 1'b0;
      periph_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      lol_count_q    <= lol_count_d;
      pll_rst_q      <= pll_rst_d;
      sys_rst_n_q    <= sys_rst_n_d;
      periph_rst_n_q <= periph_rst_n_d;
      ready_q        <= ready_d;
      fail_q         <= fail_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign periph_rst_n = periph_rst_n_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign lol_count    = lol_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timings
// (SYNC=2, PLL_RST=4, TIMEOUT=20, STABLE=8, GAP=3, RETRY=2).
// Edge numbering: edge 0 is the last edge with reset_n low; outputs are
// sampled 1 time unit after each rising edge, inputs change at that point too.

module tb_pll_reset_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pll_locked;
  logic             lol_clear;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             periph_rst_n;
  logic             ready;
  logic             fail;
  logic [CNT_W-1:0] lol_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .STAGE_GAP      (3),
    .MAX_RETRY      (2),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .periph_rst_n (periph_rst_n),
    .ready        (ready),
    .fail         (fail),
    .lol_clear    (lol_clear),
    .lol_count    (lol_count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds reset for two edges with the given lock level, then releases it.
  task automatic apply_reset(input logic lock);
    reset_n    = 1'b0;
    pll_locked = lock;
    lol_clear  = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    lol_clear  = 1'b0;
    step(3);
    obs = {pll_rst, sys_rst_n, periph_rst_n, ready, fail};
    total++;
    if (obs !== 5'b10000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=10000", obs);
    end
    total++;
    if (lol_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_lol_count got=%0d want=0", lol_count);
    end
    $display("reset: outs(pll_rst,sys,periph,ready,fail)=%b lol_count=%0d", obs, lol_count);
  endtask

  // Lock arrives after edge 10: sys_rst_n at edge 20, periph/ready at 23.
  task automatic test_power_up();
    logic [4:0] obs, exp;
    apply_reset(1'b0);
    for (int e = 1; e <= 26; e++) begin
      step(1);
      obs = {pll_rst, sys_rst_n, periph_rst_n, ready, fail};
      exp = {e < 4, e >= 20, e >= 23, e >= 23, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL power_up edge=%0d got=%b want=%b", e, obs, exp);
      end
      $display("power_up edge=%0d outs=%b", e, obs);
      if (e == 10) pll_locked = 1'b1;
    end
  endtask

  // Lock from edge 0; one-cycle dropout after edge 7, back after edge 8.
  // Qualification restarts: sys_rst_n at edge 18 instead of 12.
  task automatic test_glitch();
    logic [4:0] obs, exp;
    apply_reset(1'b0);
    pll_locked = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step(1);
      obs = {pll_rst, sys_rst_n, periph_rst_n, ready, fail};
      exp = {e < 4, e >= 18, e >= 21, e >= 21, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL glitch edge=%0d got=%b want=%b", e, obs, exp);
      end
      $display("glitch edge=%0d outs=%b", e, obs);
      if (e == 7) pll_locked = 1'b0;
      if (e == 8) pll_locked = 1'b1;
    end
  endtask

  // No lock ever: pulses at edges 0-3, 24-27, 48-51; FAIL from edge 72.
  task automatic test_fail();
    logic [4:0] obs, exp;
    logic       p;
    apply_reset(1'b0);
    for (int e = 1; e <= 80; e++) begin
      step(1);
      p   = (e < 4) || (e >= 24 && e < 28) || (e >= 48 && e < 52);
      obs = {pll_rst, sys_rst_n, periph_rst_n, ready, fail};
      exp = {p, 1'b0, 1'b0, 1'b0, e >= 72};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL timeout_fail edge=%0d got=%b want=%b", e, obs, exp);
      end
      $display("timeout_fail edge=%0d outs=%b", e, obs);
    end
  endtask

  // RUN from edge 15; lock dropped after edge 20 -> resets low at edge 23.
  task automatic test_lol();
    logic [4:0] obs, exp;
    logic [7:0] cexp;
    apply_reset(1'b0);
    pll_locked = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step(1);
      obs  = {pll_rst, sys_rst_n, periph_rst_n, ready, fail};
      exp  = {(e < 4) || (e >= 23 && e < 27), e >= 12 && e < 23,
              e >= 15 && e < 23, e >= 15 && e < 23, 1'b0};
      cexp = (e >= 23) ? 8'd1 : 8'd0;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL lol_outs edge=%0d got=%b want=%b", e, obs, exp);
      end
      total++;
      if (lol_count !== cexp) begin
        bad++;
        $display("FAIL lol_count edge=%0d got=%0d want=%0d", e, lol_count, cexp);
      end
      $display("lol edge=%0d outs=%b lol_count=%0d", e, obs, lol_count);
      if (e == 20) pll_locked = 1'b0;
    end
  endtask

  // One-cycle reset_n pulse while in REL_SYS, then the sequence replays.
  task automatic test_mid_rel_sys();
    logic [4:0] obs, exp;
    bit         seen;
    pll_locked = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1);
      if (sys_rst_n === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_rel_sys_wait got=timeout want=sys_rst_n_high");
    end
    step(1);
    total++;
    if (lol_count !== 8'd1) begin
      bad++;
      $display("FAIL mid_rel_sys_count_before got=%0d want=1", lol_count);
    end
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    obs = {pll_rst, sys_rst_n, periph_rst_n, ready, fail};
    total++;
    if (obs !== 5'b10000) begin
      bad++;
      $display("FAIL mid_rel_sys_reset got=%b want=10000", obs);
    end
    total++;
    if (lol_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_rel_sys_count got=%0d want=0", lol_count);
    end
    $display("mid_rel_sys reset: outs=%b lol_count=%0d", obs, lol_count);
    for (int e = 1; e <= 16; e++) begin
      step(1);
      obs = {pll_rst, sys_rst_n, periph_rst_n, ready, fail};
      exp = {e < 4, e >= 12, e >= 15, e >= 15, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL mid_rel_sys_replay edge=%0d got=%b want=%b", e, obs, exp);
      end
      $display("mid_rel_sys replay edge=%0d outs=%b", e, obs);
    end
  endtask

  // Drive 256 loss-of-lock events from RUN; count saturates at 255.
  // Then a clear on the same edge as an event leaves 0.
  task automatic test_saturate();
    bit         ok;
    bit         seen;
    logic [7:0] cexp;
    ok = 1;
    for (int i = 1; i <= 256 && ok; i++) begin
      pll_locked = 1'b0;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        step(1);
        if (sys_rst_n === 1'b0) seen = 1;
      end
      total++;
      if (!seen) begin
        bad++;
        ok = 0;
        $display("FAIL sat_drop event=%0d got=timeout want=sys_rst_n_low", i);
      end
      cexp = (i >= 255) ? 8'd255 : 8'(i);
      total++;
      if (lol_count !== cexp) begin
        bad++;
        $display("FAIL sat_count event=%0d got=%0d want=%0d", i, lol_count, cexp);
      end
      $display("saturate event=%0d lol_count=%0d", i, lol_count);
      pll_locked = 1'b1;
      seen = 0;
      for (int c = 0; c < 100 && !seen && ok; c++) begin
        step(1);
        total++;
        if (periph_rst_n === 1'b1 && sys_rst_n !== 1'b1) begin
          bad++;
          $display("FAIL sat_order got=periph_high_sys_low want=periph_low");
        end
        if (ready === 1'b1) seen = 1;
      end
      if (ok && !seen) begin
        total++;
        bad++;
        ok = 0;
        $display("FAIL sat_relock event=%0d got=timeout want=ready", i);
      end
    end
    // Clear lands on the edge that would increment.
    pll_locked = 1'b0;
    step(2);
    lol_clear = 1'b1;
    step(1);
    lol_clear = 1'b0;
    total++;
    if (sys_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL clear_event_reset got=%b want=0", sys_rst_n);
    end
    total++;
    if (lol_count !== 8'd0) begin
      bad++;
      $display("FAIL clear_wins got=%0d want=0", lol_count);
    end
    $display("clear with event: sys_rst_n=%b lol_count=%0d", sys_rst_n, lol_count);
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_fail();
    test_lol();
    test_mid_rel_sys();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
